// File: rtl/instr_pkg.sv
// Shared definitions for the instruction fetch path: module-select codes,
// opcodes, the instruction word layout and the fetch state encodings.
package instr_pkg;

  // Module-select codes carried on address[15:12]
  localparam logic [3:0] MainMemEn    = 4'd0;
  localparam logic [3:0] InstrMemEn   = 4'd1;
  localparam logic [3:0] MatrixAluEn  = 4'd2;
  localparam logic [3:0] IntegerAluEn = 4'd3;
  localparam logic [3:0] ExecuteEn    = 4'd4;

  // Opcodes
  localparam logic [7:0] MMULT      = 8'h00;
  localparam logic [7:0] MADD       = 8'h01;
  localparam logic [7:0] MSUB       = 8'h02;
  localparam logic [7:0] MTRANSPOSE = 8'h03;
  localparam logic [7:0] MSCALE     = 8'h04;
  localparam logic [7:0] MSCALEIMM  = 8'h05;
  localparam logic [7:0] INTADD     = 8'h10;
  localparam logic [7:0] INTSUB     = 8'h11;
  localparam logic [7:0] INTMULT    = 8'h12;
  localparam logic [7:0] INTDIV     = 8'h13;
  localparam logic [7:0] STOP       = 8'hFF;

  localparam int LINE_W = 256;
  localparam int WORD_W = 32;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] dest;
    logic [7:0] src1;
    logic [7:0] src2;
  } instr_t;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, HALT} fetch_state_e;

  // Background (prefetch) bus sequencer states
  typedef enum logic [1:0] {PF_IDLE, PF_FETCH, PF_WAIT, PF_FULL} pf_state_e;

endpackage

// File: rtl/instr_line_buffer.sv
// Line storage for the fetch sequencer: active 256-bit bank, slot pointer
// and slot mux (slot 0 = bits [255:224]). With INSTR_PREFETCH_EN defined a
// standby bank receives the prefetched line and swaps in on demand.
module instr_line_buffer
  import instr_pkg::*;
(
  input  logic                Clk,
  input  logic                nReset,
  input  logic [LINE_W-1:0]   data_i,
  input  logic                load_i,
  input  logic                adv_i,
`ifdef INSTR_PREFETCH_EN
  input  logic                pf_load_i,
  input  logic                swap_i,
`endif
  output instr_t              word_o,
  output logic                last_o
);

  logic [LINE_W-1:0] bank_q;
  logic [2:0]        slot_q;
  logic [7:0]        lsb;

`ifdef INSTR_PREFETCH_EN
  logic [LINE_W-1:0] pf_bank_q;

  // standby bank fills from the background read
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)        pf_bank_q <= '0;
    else if (pf_load_i) pf_bank_q <= data_i;
  end
`endif

  // active bank and slot pointer; a new line always restarts at slot 0
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      bank_q <= '0;
      slot_q <= '0;
    end else if (load_i) begin
      bank_q <= data_i;
      slot_q <= '0;
`ifdef INSTR_PREFETCH_EN
    end else if (swap_i) begin
      bank_q <= pf_bank_q;
      slot_q <= '0;
`endif
    end else if (adv_i) begin
      slot_q <= slot_q + 3'd1;
    end
  end

  // slot mux: lower slot numbers sit in the upper bits of the line
  always_comb begin
    lsb    = {3'd7 - slot_q, 5'd0};
    word_o = instr_t'(bank_q[lsb +: WORD_W]);
  end

  assign last_o = (slot_q == 3'd7);

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: reads 256-bit ROM lines over the shared
// address/nRead bus and hands instructions to the engine one per valid/ready
// transfer. Stops on STOP_OP or when running past the last line.
// Optional macro INSTR_PREFETCH_EN: background fetch of the next line into a
// second bank so line boundaries cost no bubble.
module instr_fetch_sequencer
  import instr_pkg::*;
#(
  parameter logic [3:0] MEM_SEL   = InstrMemEn,
  parameter int         NUM_LINES = 2,
  parameter int         READ_LAT  = 1,
  parameter logic [7:0] STOP_OP   = STOP
)(
  input  logic              Clk,
  input  logic              nReset,
  input  logic              start,
  output logic [15:0]       InstrAddress,
  output logic              InstrnRead,
  input  logic [LINE_W-1:0] InstrDataIn,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy,
  output logic              halted,
  output logic              overrun
);

  localparam logic [2:0]  LAT_LAST = 3'(READ_LAT - 1);
  localparam logic [12:0] NL       = 13'(NUM_LINES);

  fetch_state_e state_q, state_d;
  logic [11:0]  line_idx_q, line_idx_d;
  logic [2:0]   wcnt_q, wcnt_d;
  logic         halted_q, halted_d, overrun_q, overrun_d;
  logic         load, adv, xfer, last;
  logic [12:0]  nxt_idx;
  instr_t       word;

  assign nxt_idx = {1'b0, line_idx_q} + 13'd1;
  assign xfer    = instr_valid && instr_ready;

`ifdef INSTR_PREFETCH_EN
  pf_state_e    pf_state_q, pf_state_d;
  logic [2:0]   pf_cnt_q, pf_cnt_d;
  logic         pf_load, swap, kick, pf_full, pf_busy;

  assign pf_full = (pf_state_q == PF_FULL);
  assign pf_busy = (pf_state_q == PF_FETCH) || (pf_state_q == PF_WAIT);
`endif

  instr_line_buffer u_buf (
    .Clk       (Clk),
    .nReset    (nReset),
    .data_i    (InstrDataIn),
    .load_i    (load),
    .adv_i     (adv),
`ifdef INSTR_PREFETCH_EN
    .pf_load_i (pf_load),
    .swap_i    (swap),
`endif
    .word_o    (word),
    .last_o    (last)
  );

  // state register and sequencer status
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      line_idx_q <= '0;
      wcnt_q     <= '0;
      halted_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_idx_q <= line_idx_d;
      wcnt_q     <= wcnt_d;
      halted_q   <= halted_d;
      overrun_q  <= overrun_d;
    end
  end

  // next-state: fetch, wait out read latency, issue slots, advance lines
  always_comb begin
    state_d    = state_q;
    line_idx_d = line_idx_q;
    wcnt_d     = wcnt_q;
    halted_d   = halted_q;
    overrun_d  = overrun_q;
    load       = 1'b0;
    adv        = 1'b0;
`ifdef INSTR_PREFETCH_EN
    swap       = 1'b0;
    kick       = 1'b0;
`endif
    unique case (state_q)
      IDLE, HALT: if (start) begin
        halted_d   = 1'b0;
        overrun_d  = 1'b0;
        line_idx_d = '0;
        state_d    = FETCH;
      end
      FETCH: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
`ifdef INSTR_PREFETCH_EN
        // either our own read completes, or we park until the prefetch lands
        if (pf_full) begin
          swap    = 1'b1;
          kick    = nxt_idx < NL;
          state_d = ISSUE;
        end else if (!pf_busy) begin
          if (wcnt_q == LAT_LAST) begin
            load    = 1'b1;
            kick    = nxt_idx < NL;
            state_d = ISSUE;
          end else wcnt_d = wcnt_q + 3'd1;
        end
`else
        if (wcnt_q == LAT_LAST) begin
          load    = 1'b1;
          state_d = ISSUE;
        end else wcnt_d = wcnt_q + 3'd1;
`endif
      end
      ISSUE: begin
        if (word.opcode == STOP_OP) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else if (xfer) begin
          if (!last) adv = 1'b1;
          else begin
            line_idx_d = nxt_idx[11:0];
            if (nxt_idx == NL) begin
              overrun_d = 1'b1;
              state_d   = HALT;
`ifdef INSTR_PREFETCH_EN
            end else if (pf_full) begin
              swap = 1'b1;
              kick = (nxt_idx + 13'd1) < NL;
            end else if (pf_busy) begin
              state_d = WAIT;
`endif
            end else state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef INSTR_PREFETCH_EN
  // prefetch register
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      pf_state_q <= PF_IDLE;
      pf_cnt_q   <= '0;
    end else begin
      pf_state_q <= pf_state_d;
      pf_cnt_q   <= pf_cnt_d;
    end
  end

  // prefetch next-state; halting drops any line in flight or buffered
  always_comb begin
    pf_state_d = pf_state_q;
    pf_cnt_d   = pf_cnt_q;
    pf_load    = 1'b0;
    case (pf_state_q)
      PF_IDLE:  if (kick) pf_state_d = PF_FETCH;
      PF_FETCH: begin
        pf_cnt_d   = '0;
        pf_state_d = PF_WAIT;
      end
      PF_WAIT: begin
        if (pf_cnt_q == LAT_LAST) begin
          pf_load    = 1'b1;
          pf_state_d = PF_FULL;
        end else pf_cnt_d = pf_cnt_q + 3'd1;
      end
      PF_FULL:  if (swap) pf_state_d = kick ? PF_FETCH : PF_IDLE;
      default:  pf_state_d = PF_IDLE;
    endcase
    if (state_d == HALT) pf_state_d = PF_IDLE;
  end
`endif

  // outputs: one bus strobe at a time, handshake and status
  always_comb begin
    InstrnRead   = 1'b1;
    InstrAddress = '0;
    if (state_q == FETCH) begin
      InstrnRead   = 1'b0;
      InstrAddress = {MEM_SEL, line_idx_q};
    end
`ifdef INSTR_PREFETCH_EN
    else if (pf_state_q == PF_FETCH) begin
      InstrnRead   = 1'b0;
      InstrAddress = {MEM_SEL, nxt_idx[11:0]};
    end
`endif
    instr_valid = (state_q == ISSUE) && (word.opcode != STOP_OP);
    busy        = !((state_q == IDLE) || (state_q == HALT));
  end

  assign instr_out = word;
  assign halted    = halted_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Sequences the instruction ROM for the execution engine.
- Fetches 256-bit lines (8 x 32-bit instructions) over the shared address/nRead bus with module select in address[15:12].
- Buffers each line and presents one instruction at a time on a valid/ready handshake.
- Halts on the stop opcode FFh or on running past the last line.

Parameters:
- MEM_SEL, 1: module-select code driven on InstrAddress[15:12] (instruction memory enable).
- NUM_LINES, 2: number of valid ROM lines; line index range 0..NUM_LINES-1.
- READ_LAT, 1: cycles from the nRead-low sample edge to data stable on InstrDataIn; range 1..7.
- STOP_OP, 8'hFF: opcode that terminates execution.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- nReset  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins execution from line 0, slot 0. Ignored unless IDLE or HALT.
- InstrAddress  out  16  {MEM_SEL[3:0], line_idx[11:0]}.
- InstrnRead  out  1  active-low read strobe to instruction memory.
- InstrDataIn  in  256  line returned by instruction memory.
- instr_out  out  32  current instruction {opcode, dest, src1, src2}.
- instr_valid  out  1  instr_out holds an instruction for the engine.
- instr_ready  in  1  engine accepts instr_out this cycle.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  stop opcode consumed.
- overrun  out  1  line index passed NUM_LINES-1 without a stop.

Behaviour:
- Reset values (async, immediate): state IDLE; InstrnRead=1; InstrAddress=0; instr_out=0; instr_valid=0; busy=0; halted=0; overrun=0; line_idx=0; slot=0; line buffer=0.
  - Reset mid-fetch abandons the read. InstrnRead returns to 1 immediately.
- Slot order within a line:
  - slot 0 = bits [255:224], slot 7 = bits [31:0].
- Idle and start:
  - IDLE: wait for start. On start: clear halted/overrun, line_idx=0, go FETCH.
  - HALT: hold outputs. start behaves as from IDLE.
- FETCH (1 cycle): drive InstrnRead=0 and InstrAddress for line_idx, then go WAIT. InstrnRead=1 in all other states.
- WAIT (READ_LAT cycles): on the final WAIT edge, capture InstrDataIn into the line buffer, slot=0, go ISSUE.
- ISSUE: word = buffer[slot].
  - Opcode == STOP_OP: do not present it; halted=1, go HALT next edge.
  - Otherwise: instr_valid=1 with instr_out=word. instr_out must stay stable while instr_valid=1 and instr_ready=0.
  - On posedge with instr_valid && instr_ready, advance the slot:
    - slot<7: slot+1, next word presented the following cycle (1 cycle per instruction, back-to-back with ready held high).
    - slot==7: line_idx+1. If the new index == NUM_LINES: overrun=1, go HALT. Else go FETCH.
  - instr_valid drops to 0 in the cycle after the last transfer of a line.
- Worst-case line-to-line bubble: 1 + READ_LAT cycles (without prefetch).
- line_idx is 12 bits; NUM_LINES above 4096 is illegal.
- instr_ready while instr_valid=0 is ignored.
- start while busy is ignored.

Optional Feature:
- Macro: INSTR_PREFETCH_EN.
- Defined:
  - Second 256-bit buffer. When ISSUE enters slot 0 of line n and n+1 < NUM_LINES, a background fetch of n+1 runs (FETCH/WAIT timing on the bus) while issuing continues.
  - At slot 7 transfer, if the prefetch buffer is full, swap to it with zero bubble.
  - A prefetched line is discarded on halt or reset.
  - The bus never has two reads outstanding.
- Undefined: single buffer, behaviour exactly as above.

Decomposition:
- Shared package instr_pkg holds:
  - module-select constants (MainMemEn=0, InstrMemEn=1, MatrixAluEn=2, IntegerAluEn=3, ExecuteEn=4);
  - opcode localparams (MMULT 00h … MSCALEIMM 05h, INTADD 10h … INTDIV 13h, STOP FFh);
  - packed struct instr_t {opcode, dest, src1, src2};
  - fetch state enum {IDLE, FETCH, WAIT, ISSUE, HALT}.
- One natural sub-module: instr_line_buffer, holding the 256-bit storage, slot select/mux, and the optional prefetch second bank.

Test Plan:
- Normal run: line 0 holds 8 non-stop words, line 1 holds FF000000 at slot 0, ready=1. Expect:
  - InstrnRead low for 1 cycle at address 1000h, later at 1001h;
  - 8 transfers in 8 consecutive cycles in slot order;
  - halted=1; no ninth transfer.
- Backpressure: ready=0 for 5 cycles on slot 3. Expect instr_out held, instr_valid=1, then the transfer, then slot 4.
- Overrun: NUM_LINES=2, no stop in either line. Expect 16 transfers, overrun=1, HALT, busy=0.
- Reset mid-WAIT: assert nReset low during WAIT. Expect all outputs at reset values immediately; after start, fetch restarts at 1000h.
- Stop mid-line: line 0 slot 2 = FF000000. Expect exactly 2 transfers, no further bus reads, halted=1. A new start re-fetches line 0.
- INSTR_PREFETCH_EN, READ_LAT=3, ready=1. Expect 16 instructions in 16 consecutive cycles with no bubble at the line boundary.
